// File: rtl/table_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : table_loader_pkg
//  Purpose  : Shared types and constants for the table loader. Holds the
//             loader state encoding, the default table geometry and the
//             number of byte lanes packed into each SRAM word.
//  Contents : state_t        - loader FSM state (IDLE/COLLECT/WRITE/DONE)
//             DEPTH_DEFAULT  - default number of words per load
//             ADDR_W_DEFAULT - default SRAM address width
//             LANES          - bytes per SRAM word
//             LANE_W         - width of the lane counter
//             WORD_W         - SRAM word width in bits
//  Revision : 1.0 - initial release
// ============================================================================
package table_loader_pkg;

   localparam int DEPTH_DEFAULT  = 256;
   localparam int ADDR_W_DEFAULT = 8;

   localparam int LANES  = 4;
   localparam int LANE_W = $clog2(LANES);
   localparam int WORD_W = 8 * LANES;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/table_loader_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : word_assembler
//  Purpose  : Packs accepted bytes into little-endian SRAM words and keeps a
//             running modulo-256 checksum of every accepted byte.
//  Ports    : clk        in  1       - clock
//             reset      in  1       - synchronous active-high reset
//             clear      in  1       - restart: lane count, lanes, csum to 0
//             accept     in  1       - a byte transfers this cycle
//             data       in  8       - byte being transferred
//             word_ready out 1       - this accept completes a word
//             word       out WORD_W  - completed word, valid with word_ready
//             csum       out 8       - registered byte checksum
//  Revision : 1.0 - initial release
// ============================================================================
module word_assembler
   import table_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              accept,
   input  logic [7:0]        data,
   output logic              word_ready,
   output logic [WORD_W-1:0] word,
   output logic [7:0]        csum
);

   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   logic [LANE_W-1:0]   lane_cnt;
   // Only the first LANES-1 bytes are stored; the final byte is merged
   // combinationally so the finished word is available on its accept cycle.
   logic [WORD_W-9:0]   lanes;

   // New bytes enter at the top and shift down, so after LANES-1 accepts the
   // oldest byte sits in bits 7:0 (lane 0).
   assign word_ready = accept && (lane_cnt == LAST_LANE);
   assign word       = {data, lanes};

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         lane_cnt <= '0;
         lanes    <= '0;
         csum     <= '0;
      end else if (accept) begin
         lane_cnt <= (lane_cnt == LAST_LANE) ? '0 : lane_cnt + LANE_W'(1);
         lanes    <= {data, lanes[WORD_W-9:8]};
         csum     <= csum + data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/table_loader.sv
`default_nettype none
// ============================================================================
//  Module   : table_loader
//  Purpose  : Collects a byte stream into 32-bit words and writes DEPTH
//             consecutive words into an SRAM write port starting at address
//             0, reporting completion with a one-cycle done pulse and a
//             modulo-256 checksum of the bytes received.
//  Ports    : clk      in  1       - clock
//             reset    in  1       - synchronous active-high reset
//             start    in  1       - begin a load (honoured only in IDLE)
//             abort    in  1       - terminate a load in progress
//             s_valid  in  1       - byte-stream valid
//             s_data   in  8       - byte-stream data
//             s_ready  out 1       - byte-stream ready
//             csb0     out 1       - SRAM select, active low
//             web0     out 1       - SRAM write enable, active low
//             wmask0   out 4       - SRAM byte write mask
//             addr0    out ADDR_W  - SRAM address
//             din0     out 32      - SRAM write data
//             busy     out 1       - load in progress
//             done     out 1       - one-cycle completion pulse
//             csum     out 8       - byte checksum since last start
//  Revision : 1.0 - initial release
// ============================================================================
module table_loader
   import table_loader_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              csb0,
   output logic              web0,
   output logic [LANES-1:0]  wmask0,
   output logic [ADDR_W-1:0] addr0,
   output logic [WORD_W-1:0] din0,
   output logic              busy,
   output logic              done,
   output logic [7:0]        csum
);

   localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(DEPTH - 1);

   state_t              state;
   state_t              state_next;
   logic [ADDR_W-1:0]   index;
   logic [ADDR_W-1:0]   index_next;

   logic                s_ready_next;
   logic                csb0_next;
   logic                web0_next;
   logic [LANES-1:0]    wmask0_next;
   logic [ADDR_W-1:0]   addr0_next;
   logic [WORD_W-1:0]   din0_next;
   logic                busy_next;
   logic                done_next;

   logic                accept;
   logic                clear;
   logic                word_ready;
   logic [WORD_W-1:0]   word;

   // s_ready is a registered copy of "state is COLLECT", so the handshake
   // needs no further qualification by state.
   assign accept = s_valid && s_ready;

   word_assembler u_assembler (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .accept     (accept),
      .data       (s_data),
      .word_ready (word_ready),
      .word       (word),
      .csum       (csum)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         index   <= '0;
         s_ready <= 1'b0;
         csb0    <= 1'b1;
         web0    <= 1'b1;
         wmask0  <= '0;
         addr0   <= '0;
         din0    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_next;
         index   <= index_next;
         s_ready <= s_ready_next;
         csb0    <= csb0_next;
         web0    <= web0_next;
         wmask0  <= wmask0_next;
         addr0   <= addr0_next;
         din0    <= din0_next;
         busy    <= busy_next;
         done    <= done_next;
      end
   end

   always_comb begin
      state_next   = state;
      index_next   = index;
      clear        = 1'b0;

      s_ready_next = 1'b0;
      csb0_next    = 1'b1;
      web0_next    = 1'b1;
      wmask0_next  = '0;
      addr0_next   = addr0;
      din0_next    = din0;
      busy_next    = 1'b1;
      done_next    = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start && !abort) begin
               state_next = ST_COLLECT;
               index_next = '0;
               clear      = 1'b1;
            end
         end
         ST_COLLECT: begin
            if (abort) begin
               state_next = ST_IDLE;
            end else if (word_ready) begin
               state_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // The strobe for this cycle is already on the port; abort only
            // decides where we go next.
            if (abort) begin
               state_next = ST_IDLE;
            end else if (index == LAST_INDEX) begin
               state_next = ST_DONE;
               index_next = '0;
            end else begin
               state_next = ST_COLLECT;
               index_next = index + ADDR_W'(1);
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so every port is a flop
      // that lines up exactly with the state it describes.
      case (state_next)
         ST_IDLE: begin
            busy_next = 1'b0;
         end
         ST_COLLECT: begin
            s_ready_next = 1'b1;
         end
         ST_WRITE: begin
            csb0_next   = 1'b0;
            web0_next   = 1'b0;
            wmask0_next = {LANES{1'b1}};
            addr0_next  = index;
            din0_next   = word;
         end
         ST_DONE: begin
            done_next = 1'b1;
         end
         default: begin
            busy_next = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_table_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_table_loader
//  Purpose  : Self-checking bench for table_loader. A negedge monitor logs
//             every SRAM write strobe and done pulse; scenario tasks compare
//             the log and the ports against expectations computed from the
//             byte stream they drove.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_table_loader;

   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              abort;
   logic              s_valid;
   logic [7:0]        s_data;
   logic              s_ready;
   logic              csb0;
   logic              web0;
   logic [3:0]        wmask0;
   logic [ADDR_W-1:0] addr0;
   logic [31:0]       din0;
   logic              busy;
   logic              done;
   logic [7:0]        csum;

   int total = 0;
   int bad   = 0;

   logic [ADDR_W-1:0] wr_addr[$];
   logic [31:0]       wr_data[$];
   logic [3:0]        wr_mask[$];
   int                wr_web_bad = 0;
   int                done_cnt   = 0;
   logic [7:0]        stim_q[$];

   table_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .abort   (abort),
      .s_valid (s_valid),
      .s_data  (s_data),
      .s_ready (s_ready),
      .csb0    (csb0),
      .web0    (web0),
      .wmask0  (wmask0),
      .addr0   (addr0),
      .din0    (din0),
      .busy    (busy),
      .done    (done),
      .csum    (csum)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (csb0 === 1'b0) begin
         wr_addr.push_back(addr0);
         wr_data.push_back(din0);
         wr_mask.push_back(wmask0);
         if (web0 !== 1'b0) wr_web_bad++;
      end
      if (done === 1'b1) done_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_mask.delete();
      wr_web_bad = 0;
      done_cnt   = 0;
   endtask

   task automatic quick_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   // Idles for 'gap' cycles (optionally pulsing start on the first one),
   // then offers the byte until the handshake completes.
   task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
      logic rdy;
      int   n;
      s_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         start = noise && (g == 0);
         step();
         start = 1'b0;
      end
      s_valid = 1'b1;
      s_data  = b;
      n       = 0;
      do begin
         rdy = s_ready;
         step();
         n++;
      end while (!rdy && n < 40);
      s_valid = 1'b0;
      if (!rdy) begin
         total++; bad++;
         $display("FAIL send_timeout byte=%h got s_ready=0 want handshake within 40 cycles", b);
      end
   endtask

   function automatic logic [31:0] sine_word(input int i);
      real   r;
      longint v;
      r = $sin(i * 3.14159265358979323846 / 128.0) * 2147483647.0;
      v = longint'(r);
      return v[31:0];
   endfunction

   function automatic logic [31:0] model_word(input int i);
      return {stim_q[4*i+3], stim_q[4*i+2], stim_q[4*i+1], stim_q[4*i]};
   endfunction

   function automatic logic [7:0] model_csum(input int first, input int count);
      int s = 0;
      for (int k = first; k < first + count; k++) s += int'(stim_q[k]);
      return 8'(s % 256);
   endfunction

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      repeat (3) step();
      total++; if (csb0 !== 1'b1)    begin bad++; $display("FAIL reset_csb0 got=%b want=1", csb0); end
      total++; if (web0 !== 1'b1)    begin bad++; $display("FAIL reset_web0 got=%b want=1", web0); end
      total++; if (wmask0 !== 4'h0)  begin bad++; $display("FAIL reset_wmask0 got=%h want=0", wmask0); end
      total++; if (addr0 !== '0)     begin bad++; $display("FAIL reset_addr0 got=%h want=0", addr0); end
      total++; if (din0 !== 32'h0)   begin bad++; $display("FAIL reset_din0 got=%h want=0", din0); end
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready got=%b want=0", s_ready); end
      total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (csum !== 8'h0)    begin bad++; $display("FAIL reset_csum got=%h want=0", csum); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_basic_word();
      clear_log();
      pulse_start();
      total++; if (busy !== 1'b1 || s_ready !== 1'b1) begin bad++; $display("FAIL basic_collect busy=%b s_ready=%b want 1 1", busy, s_ready); end
      send_byte(8'h78, 0, 1'b0);
      send_byte(8'h56, 0, 1'b0);
      send_byte(8'h34, 0, 1'b0);
      send_byte(8'h12, 0, 1'b0);
      total++; if (csb0 !== 1'b0 || web0 !== 1'b0) begin bad++; $display("FAIL basic_strobe csb0=%b web0=%b want 0 0", csb0, web0); end
      total++; if (wmask0 !== 4'hF)      begin bad++; $display("FAIL basic_wmask got=%h want=f", wmask0); end
      total++; if (addr0 !== 8'd0)       begin bad++; $display("FAIL basic_addr got=%h want=0", addr0); end
      total++; if (din0 !== 32'h12345678) begin bad++; $display("FAIL basic_din got=%h want=12345678", din0); end
      total++; if (s_ready !== 1'b0)     begin bad++; $display("FAIL basic_write_ready got=%b want=0", s_ready); end
      total++; if (csum !== 8'h14)       begin bad++; $display("FAIL basic_csum got=%h want=14", csum); end
      step();
      total++; if (csb0 !== 1'b1 || wmask0 !== 4'h0) begin bad++; $display("FAIL basic_release csb0=%b wmask0=%h want 1 0", csb0, wmask0); end
      total++; if (din0 !== 32'h12345678 || addr0 !== 8'd0) begin bad++; $display("FAIL basic_hold din0=%h addr0=%h want 12345678 0", din0, addr0); end
      total++; if (s_ready !== 1'b1)     begin bad++; $display("FAIL basic_next_ready got=%b want=1", s_ready); end
      pulse_abort();
   endtask

   task automatic test_stall();
      logic [7:0] b[4];
      for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
      quick_reset();
      clear_log();
      pulse_start();
      send_byte(b[0], 0, 1'b0);
      send_byte(b[1], 0, 1'b0);
      for (int g = 0; g < 7; g++) begin
         step();
         total++; if (csb0 !== 1'b1) begin bad++; $display("FAIL stall_no_write cycle=%0d csb0=%b want=1", g, csb0); end
         total++; if (din0 !== 32'h0) begin bad++; $display("FAIL stall_din_hold cycle=%0d got=%h want=0", g, din0); end
      end
      send_byte(b[2], 0, 1'b0);
      total++; if (csb0 !== 1'b1) begin bad++; $display("FAIL stall_third csb0=%b want=1", csb0); end
      send_byte(b[3], 0, 1'b0);
      total++; if (csb0 !== 1'b0 || addr0 !== 8'd0) begin bad++; $display("FAIL stall_write csb0=%b addr0=%h want 0 0", csb0, addr0); end
      total++; if (din0 !== {b[3], b[2], b[1], b[0]}) begin bad++; $display("FAIL stall_din got=%h want=%h", din0, {b[3], b[2], b[1], b[0]}); end
      step();
      total++; if (wr_addr.size() != 1) begin bad++; $display("FAIL stall_write_count got=%0d want=1", wr_addr.size()); end
      pulse_abort();
   endtask

   task automatic test_abort();
      int hit5 = 0;
      quick_reset();
      clear_log();
      stim_q.delete();
      for (int k = 0; k < 22; k++) stim_q.push_back(8'($urandom));
      pulse_start();
      foreach (stim_q[k]) send_byte(stim_q[k], 0, 1'b0);
      pulse_abort();
      total++; if (busy !== 1'b0 || s_ready !== 1'b0) begin bad++; $display("FAIL abort_idle busy=%b s_ready=%b want 0 0", busy, s_ready); end
      repeat (5) step();
      foreach (wr_addr[k]) if (wr_addr[k] == 8'd5) hit5++;
      total++; if (wr_addr.size() != 5) begin bad++; $display("FAIL abort_write_count got=%0d want=5", wr_addr.size()); end
      total++; if (hit5 != 0) begin bad++; $display("FAIL abort_addr5 got=%0d writes want=0", hit5); end
      total++; if (done_cnt != 0) begin bad++; $display("FAIL abort_done got=%0d pulses want=0", done_cnt); end
      stim_q.delete();
      for (int k = 0; k < 4; k++) stim_q.push_back(8'($urandom));
      pulse_start();
      total++; if (csum !== 8'h00) begin bad++; $display("FAIL abort_restart_csum_clear got=%h want=0", csum); end
      foreach (stim_q[k]) send_byte(stim_q[k], 0, 1'b0);
      total++; if (addr0 !== 8'd0 || csb0 !== 1'b0) begin bad++; $display("FAIL abort_restart_addr addr0=%h csb0=%b want 0 0", addr0, csb0); end
      total++; if (din0 !== model_word(0)) begin bad++; $display("FAIL abort_restart_din got=%h want=%h", din0, model_word(0)); end
      total++; if (csum !== model_csum(0, 4)) begin bad++; $display("FAIL abort_restart_csum got=%h want=%h", csum, model_csum(0, 4)); end
      pulse_abort();
   endtask

   task automatic test_reset_mid_write();
      quick_reset();
      clear_log();
      stim_q.delete();
      for (int k = 0; k < 44; k++) stim_q.push_back(8'($urandom));
      pulse_start();
      foreach (stim_q[k]) send_byte(stim_q[k], (k == 13 || k == 30) ? 2 : 0, (k == 13 || k == 30));
      total++; if (csb0 !== 1'b0 || addr0 !== 8'd10) begin bad++; $display("FAIL midreset_write csb0=%b addr0=%h want 0 0a", csb0, addr0); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      total++; if (csb0 !== 1'b1 || web0 !== 1'b1) begin bad++; $display("FAIL midreset_strobe csb0=%b web0=%b want 1 1", csb0, web0); end
      total++; if (wmask0 !== 4'h0 || addr0 !== '0) begin bad++; $display("FAIL midreset_mask_addr wmask0=%h addr0=%h want 0 0", wmask0, addr0); end
      total++; if (din0 !== 32'h0) begin bad++; $display("FAIL midreset_din got=%h want=0", din0); end
      total++; if (s_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midreset_ctrl s_ready=%b busy=%b done=%b want 0 0 0", s_ready, busy, done); end
      total++; if (csum !== 8'h0) begin bad++; $display("FAIL midreset_csum got=%h want=0", csum); end
      total++; if (wr_addr.size() != 11) begin bad++; $display("FAIL midreset_write_count got=%0d want=11", wr_addr.size()); end
      for (int i = 0; i < 11 && i < wr_addr.size(); i++) begin
         total++; if (wr_addr[i] !== 8'(i) || wr_data[i] !== model_word(i)) begin
            bad++; $display("FAIL midreset_seq[%0d] addr=%h data=%h want %h %h", i, wr_addr[i], wr_data[i], 8'(i), model_word(i));
         end
      end
   endtask

   task automatic test_full_load(input bit use_sine);
      logic [31:0] w;
      logic [7:0]  exp_csum;
      int          n;
      int          gap;
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      clear_log();
      stim_q.delete();
      for (int i = 0; i < DEPTH; i++) begin
         w = use_sine ? sine_word(i) : $urandom;
         for (int k = 0; k < 4; k++) stim_q.push_back(w[8*k +: 8]);
      end
      exp_csum = model_csum(0, 4 * DEPTH);
      pulse_start();
      foreach (stim_q[k]) begin
         gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         send_byte(stim_q[k], gap, $urandom_range(0, 3) == 0);
         if (k == 500) begin
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy got=%b want=1", busy); end
         end
      end
      n = 0;
      while (done !== 1'b1 && n < 10) begin step(); n++; end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL full_done_timeout got done=%b want=1", done); end
      total++; if (csum !== exp_csum) begin bad++; $display("FAIL full_csum_at_done got=%h want=%h", csum, exp_csum); end
      step();
      total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL full_idle done=%b busy=%b want 0 0", done, busy); end
      repeat (3) step();
      total++; if (done_cnt != 1) begin bad++; $display("FAIL full_done_count got=%0d want=1", done_cnt); end
      total++; if (csum !== exp_csum) begin bad++; $display("FAIL full_csum_stable got=%h want=%h", csum, exp_csum); end
      total++; if (wr_addr.size() != DEPTH) begin bad++; $display("FAIL full_write_count got=%0d want=%0d", wr_addr.size(), DEPTH); end
      total++; if (wr_web_bad != 0) begin bad++; $display("FAIL full_web0 got=%0d bad strobes want=0", wr_web_bad); end
      for (int i = 0; i < DEPTH && i < wr_addr.size(); i++) begin
         total++; if (wr_addr[i] !== 8'(i) || wr_data[i] !== model_word(i) || wr_mask[i] !== 4'hF) begin
            bad++; $display("FAIL full_mem[%0d] addr=%h data=%h mask=%h want %h %h f", i, wr_addr[i], wr_data[i], wr_mask[i], 8'(i), model_word(i));
         end
      end
      if (use_sine) begin
         total++; if (model_word(64) !== 32'h7FFFFFFF || model_word(0) !== 32'h0) begin
            bad++; $display("FAIL sine_table w0=%h w64=%h want 0 7fffffff", model_word(0), model_word(64));
         end
      end
   endtask

   task automatic test_start_abort_same_cycle();
      quick_reset();
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      total++; if (busy !== 1'b0 || s_ready !== 1'b0) begin bad++; $display("FAIL start_abort busy=%b s_ready=%b want 0 0", busy, s_ready); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      test_reset();
      test_basic_word();
      test_stall();
      test_abort();
      test_reset_mid_write();
      test_start_abort_same_cycle();
      test_full_load(1'b1);
      test_full_load(1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
